axis_stream_arbiter: RTL
========================

# axis_stream_arbiter

Packet-granular round-robin arbiter that shares one AXI4-Stream datapath (the TEA encryptor/decryptor stream input) between up to four stream sources, e.g. several BMP stimulus generators. It holds a grant from the first beat to the TLAST beat of a packet, so packets are never interleaved. Output is registered, and the stream ID is tagged so downstream can route results back to the source.

## Interface
Parameters:
- NUM_SRC, 2, number of slave stream ports, legal 2..4
- STREAM_WIDTH_DATA, 64, TDATA width
- STREAM_WIDTH_DS, STREAM_WIDTH_DATA/8, TSTRB/TKEEP width
- STREAM_WIDTH_TID, 8, TID width
- STREAM_WIDTH_TDEST, 3, TDEST width, must be at least 2

Ports:
- ARESETn  in  1  asynchronous active-low reset
- ACLK  in  1  single clock, all logic on rising edge
- S_TVALID  in  NUM_SRC  per-source valid
- S_TREADY  out  NUM_SRC  per-source ready
- S_TDATA  in  NUM_SRC*STREAM_WIDTH_DATA  source i in slice i
- S_TSTRB, S_TKEEP  in  NUM_SRC*STREAM_WIDTH_DS  per-source strobes
- S_TLAST  in  NUM_SRC  end of packet
- S_TID  in  NUM_SRC*STREAM_WIDTH_TID  per-source ID
- S_TDEST  in  NUM_SRC*STREAM_WIDTH_TDEST  per-source destination
- M_TVALID, M_TDATA, M_TSTRB, M_TKEEP, M_TLAST, M_TID, M_TDEST  out  matching widths  arbitrated stream
- M_TREADY  in  1  downstream ready
- grant_idx  out  2  currently or last granted source
- busy  out  1  packet in progress

## Operation
- States: IDLE and BUSY.
- IDLE: if any S_TVALID is high, pick the first valid source searching from (last_grant+1) mod NUM_SRC upward with wrap. Register it into grant_idx and go to BUSY. All S_TREADY are 0 in IDLE.
- BUSY: S_TREADY[grant_idx] = !M_TVALID || M_TREADY. All other S_TREADY are 0.
- Accepted beat (S_TVALID & S_TREADY of the granted source): loads the output register.
- Accepted beat with TLAST=1: return to IDLE and update last_grant = grant_idx.
- Output register: M_TVALID is set on acceptance. It clears when M_TREADY=1 and no new beat is accepted in the same cycle. Output fields are held stable while M_TVALID=1 and M_TREADY=0.
- Sources with S_TVALID low at arbitration time are skipped. A granted source may deassert TVALID mid-packet; the grant is held (no timeout).
- Reset mid-packet: all state clears immediately. The partial packet is dropped, and the next packet starts fresh from source 0 priority.
- Reset values: M_TVALID=0, M_TLAST=0, M_TDATA/M_TSTRB/M_TKEEP/M_TID/M_TDEST=0, S_TREADY=0, grant_idx=0, busy=0, last_grant=NUM_SRC-1 (so source 0 wins the first arbitration), state=IDLE.

## Timing
- Arbitration takes 1 cycle (the IDLE cycle). The first beat can be accepted on the following edge.
- Minimum inter-packet gap on M is 1 cycle. Within a packet, throughput is 1 beat per cycle when M_TREADY=1.
- Latency is 1 cycle from S acceptance to M_TVALID.
- busy = (state==BUSY), registered.
- Back-to-back 1-beat packets (TLAST on the first beat) give M_TVALID high on alternate cycles.

## Configuration
- AXIS_ARB_TDEST_TAG_EN defined: M_TDEST = {zero-extend, grant_idx}; the source TDEST is discarded.
- AXIS_ARB_TDEST_TAG_EN not defined: M_TDEST = the granted source's TDEST, passed through.
- TID passes through in both cases.

## Structure
- Package axis_arb_pkg holds:
  - the state encoding (IDLE=1'b0, BUSY=1'b1)
  - MAX_SRC=4
  - the grant index width constant (2)
- Sub-module axis_rr_pick: a combinational round-robin priority picker with inputs req[NUM_SRC] and last[1:0], and outputs pick[1:0] and any. It is instantiated once.
- The top holds the FSM, the output register and the ready generation.

## Test plan
- Single source: source 0 sends a 40-beat packet (TLAST on beat 40), with M_TREADY=1 -> M carries 40 beats in order, M_TLAST only on beat 40, first M_TVALID 2 cycles after S_TVALID rises.
- Contention: sources 0 and 1 are both valid at reset release, each sending 3-beat packets continuously -> the M packet order is 0,1,0,1 with no interleaving and a 1-cycle gap between packets.
- Backpressure: M_TREADY is toggled 1,0,0,1 during a packet -> no beat lost or duplicated, M_TDATA is stable while stalled, and S_TREADY[g]=0 in stall cycles while M_TVALID=1.
- Skip/wrap: NUM_SRC=4 with last_grant=1, and only sources 0 and 3 valid -> source 3 is granted next, then source 0.
- TDEST tag: with AXIS_ARB_TDEST_TAG_EN defined, source 2 sends S_TDEST=5 -> M_TDEST=2. Without the macro -> M_TDEST=5.
- Reset mid-packet: ARESETn is dropped on beat 2 of a 4-beat packet from source 1 -> M_TVALID=0 and busy=0 immediately. After release, with source 1 valid, source 1 is granted on the first arbitration.

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared encodings and constants for the packet-granular AXI4-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_t;

    localparam int MAX_SRC = 4;
    localparam int GRANT_W = 2;

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping at NUM_SRC.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [GRANT_W-1:0] last,
    output logic [GRANT_W-1:0] pick,
    output logic               any
);

    always_comb begin
        pick = '0;
        any  = 1'b0;
        // Offset k=1 is the highest priority; k=NUM_SRC lets 'last' itself win if alone.
        for (int k = 1; k <= NUM_SRC; k++) begin
            for (int j = 0; j < NUM_SRC; j++) begin
                if (!any && req[j] && (((int'(last) + k) % NUM_SRC) == j)) begin
                    pick = GRANT_W'(j);
                    any  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_stream_arbiter.sv
// Round-robin, packet-granular AXI4-Stream arbiter with a registered output stage.
// Define AXIS_ARB_TDEST_TAG_EN to replace M_TDEST with the granted source index.
module axis_stream_arbiter
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC            = 2,
    parameter int STREAM_WIDTH_DATA  = 64,
    parameter int STREAM_WIDTH_DS    = STREAM_WIDTH_DATA/8,
    parameter int STREAM_WIDTH_TID   = 8,
    parameter int STREAM_WIDTH_TDEST = 3
) (
    input  logic                                   ARESETn,
    input  logic                                   ACLK,
    input  logic [NUM_SRC-1:0]                     S_TVALID,
    output logic [NUM_SRC-1:0]                     S_TREADY,
    input  logic [NUM_SRC*STREAM_WIDTH_DATA-1:0]   S_TDATA,
    input  logic [NUM_SRC*STREAM_WIDTH_DS-1:0]     S_TSTRB,
    input  logic [NUM_SRC*STREAM_WIDTH_DS-1:0]     S_TKEEP,
    input  logic [NUM_SRC-1:0]                     S_TLAST,
    input  logic [NUM_SRC*STREAM_WIDTH_TID-1:0]    S_TID,
    input  logic [NUM_SRC*STREAM_WIDTH_TDEST-1:0]  S_TDEST,
    output logic                                   M_TVALID,
    input  logic                                   M_TREADY,
    output logic [STREAM_WIDTH_DATA-1:0]           M_TDATA,
    output logic [STREAM_WIDTH_DS-1:0]             M_TSTRB,
    output logic [STREAM_WIDTH_DS-1:0]             M_TKEEP,
    output logic                                   M_TLAST,
    output logic [STREAM_WIDTH_TID-1:0]            M_TID,
    output logic [STREAM_WIDTH_TDEST-1:0]          M_TDEST,
    output logic [GRANT_W-1:0]                     grant_idx,
    output logic                                   busy
);

    // state   | meaning
    // ST_IDLE | no packet owns the datapath; arbitrate among valid sources
    // ST_BUSY | grant_idx owns the datapath until its TLAST beat is accepted

    arb_state_t                      state;
    logic [GRANT_W-1:0]              last_grant;
    logic [GRANT_W-1:0]              pick;
    logic                            pick_any;

    logic                            sel_valid;
    logic                            sel_ready;
    logic                            sel_last;
    logic [STREAM_WIDTH_DATA-1:0]    sel_data;
    logic [STREAM_WIDTH_DS-1:0]      sel_strb;
    logic [STREAM_WIDTH_DS-1:0]      sel_keep;
    logic [STREAM_WIDTH_TID-1:0]     sel_tid;
`ifndef AXIS_ARB_TDEST_TAG_EN
    logic [STREAM_WIDTH_TDEST-1:0]   sel_tdest;
`endif
    logic                            accept;

    axis_rr_pick #(.NUM_SRC(NUM_SRC)) u_pick (
        .req  (S_TVALID),
        .last (last_grant),
        .pick (pick),
        .any  (pick_any)
    );

    // Output slot is free when empty or draining this cycle.
    assign sel_ready = (state == ST_BUSY) && (!M_TVALID || M_TREADY);
    assign accept    = sel_valid && sel_ready;

    always_comb begin
        S_TREADY  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_strb  = '0;
        sel_keep  = '0;
        sel_tid   = '0;
`ifndef AXIS_ARB_TDEST_TAG_EN
        sel_tdest = '0;
`endif
        for (int i = 0; i < NUM_SRC; i++) begin
            if (grant_idx == GRANT_W'(i)) begin
                S_TREADY[i] = sel_ready;
                sel_valid   = S_TVALID[i];
                sel_last    = S_TLAST[i];
                sel_data    = S_TDATA[i*STREAM_WIDTH_DATA +: STREAM_WIDTH_DATA];
                sel_strb    = S_TSTRB[i*STREAM_WIDTH_DS +: STREAM_WIDTH_DS];
                sel_keep    = S_TKEEP[i*STREAM_WIDTH_DS +: STREAM_WIDTH_DS];
                sel_tid     = S_TID[i*STREAM_WIDTH_TID +: STREAM_WIDTH_TID];
`ifndef AXIS_ARB_TDEST_TAG_EN
                sel_tdest   = S_TDEST[i*STREAM_WIDTH_TDEST +: STREAM_WIDTH_TDEST];
`endif
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            last_grant <= GRANT_W'(NUM_SRC - 1);
            busy       <= 1'b0;
            M_TVALID   <= 1'b0;
            M_TLAST    <= 1'b0;
            M_TDATA    <= '0;
            M_TSTRB    <= '0;
            M_TKEEP    <= '0;
            M_TID      <= '0;
            M_TDEST    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_idx <= pick;
                        state     <= ST_BUSY;
                        busy      <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (accept && sel_last) begin
                        state      <= ST_IDLE;
                        busy       <= 1'b0;
                        last_grant <= grant_idx;
                    end
                end
            endcase

            if (accept) begin
                M_TVALID <= 1'b1;
                M_TLAST  <= sel_last;
                M_TDATA  <= sel_data;
                M_TSTRB  <= sel_strb;
                M_TKEEP  <= sel_keep;
                M_TID    <= sel_tid;
`ifdef AXIS_ARB_TDEST_TAG_EN
                M_TDEST  <= STREAM_WIDTH_TDEST'(grant_idx);
`else
                M_TDEST  <= sel_tdest;
`endif
            end else if (M_TREADY) begin
                M_TVALID <= 1'b0;
            end
        end
    end

endmodule
